// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data RAM, branch resolution, multi-cycle load stall and MEM/WB register.
module mem_stage #(
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic [7:0] ex_alu_result,
  input  logic [7:0] ex_store_data,
  input  logic [3:0] ex_dest,
  input  logic [1:0] ex_mem_ctrl,
  input  logic [1:0] ex_wb_ctrl,
  input  logic [3:0] ex_branch_taken,
  input  logic [7:0] ex_branch_target,
  output logic       pc_src,
  output logic [7:0] branch_target,
  output logic       flush,
  output logic       stall,
  output logic       mem_regwrt,
  output logic [3:0] mem_dest,
  output logic [7:0] mem_data,
  output logic       wb_regwrt,
  output logic [3:0] wb_dest,
  output logic [7:0] wb_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef struct packed {
    logic       v;
    logic [7:0] alu;
    logic [7:0] sd;
    logic [3:0] dest;
    logic       we;
    logic [1:0] wc;
    logic [3:0] bt;
    logic [7:0] tgt;
  } exmem_t;
  typedef struct packed {
    logic       v;
    logic       rw;
    logic [3:0] dest;
    logic [7:0] data;
  } memwb_t;
  exmem_t        ex_q, ex_d, ex_in;
  memwb_t        wb_q, wb_d, wb_in;
  state_t        st_q, st_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    ram [DEPTH];
  logic [AW-1:0] addr;
  logic          done, go_wait;
  assign stall         = st_q == S_WAIT;
  assign done          = stall && cnt_q == 3'd1;
  assign pc_src        = ex_q.v && |ex_q.bt && !stall;
  assign flush         = pc_src;
  assign branch_target = ex_q.tgt;
  assign addr          = ex_q.alu[AW-1:0];
  // The wait starts as the load enters EX/MEM so the stall lasts exactly RD_LATENCY-1 cycles.
  assign go_wait = RD_LATENCY > 1 && !stall && !pc_src && ex_valid && ex_mem_ctrl == 2'b10;
  assign mem_regwrt = ex_q.v && ex_q.wc[1];
  assign mem_dest   = ex_q.v ? ex_q.dest : 4'h0;
  assign mem_data   = ex_q.v ? ex_q.alu : 8'h00;
  assign wb_regwrt  = wb_q.v && wb_q.rw;
  assign wb_dest    = wb_q.v ? wb_q.dest : 4'h0;
  assign wb_data    = wb_q.v ? wb_q.data : 8'h00;
  // On the final wait edge the finished load leaves EX/MEM as a bubble; the frozen upstream re-presents the next op.
  always_comb begin
    ex_in = exmem_t'{v: ex_valid, alu: ex_alu_result, sd: ex_store_data, dest: ex_dest,
                     we: ex_mem_ctrl[0], wc: ex_wb_ctrl, bt: ex_branch_taken, tgt: ex_branch_target};
    wb_in = memwb_t'{v: ex_q.v, rw: ex_q.wc[1], dest: ex_q.dest,
                     data: ex_q.wc[0] ? ram[addr] : ex_q.alu};
    ex_d  = stall ? (done ? exmem_t'(0) : ex_q) : (pc_src ? exmem_t'(0) : ex_in);
    wb_d  = (stall && !done) ? memwb_t'(0) : wb_in;
    st_d  = go_wait ? S_WAIT : (done ? S_IDLE : st_q);
    cnt_d = go_wait ? 3'(RD_LATENCY - 1) : (stall ? cnt_q - 3'd1 : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      wb_q  <= '0;
      st_q  <= S_IDLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      wb_q  <= wb_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ex_q.v && ex_q.we && !stall) ram[addr] <= ex_q.sd;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table for the single-cycle instance, hand sequences for the 3-cycle load instance.
module tb_mem_stage;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       v;
  logic [7:0] alu, sd, tgt;
  logic [3:0] dest, bt;
  logic [1:0] mc, wc;
  logic       pc1, fl1, st1, mrw1, wrw1, pc3, fl3, st3, mrw3, wrw3;
  logic [7:0] bt1, md1d, wd1d, bt3, md3d, wd3d;
  logic [3:0] md1, wd1, md3, wd3;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .RD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(v), .ex_alu_result(alu), .ex_store_data(sd),
    .ex_dest(dest), .ex_mem_ctrl(mc), .ex_wb_ctrl(wc), .ex_branch_taken(bt), .ex_branch_target(tgt),
    .pc_src(pc1), .branch_target(bt1), .flush(fl1), .stall(st1), .mem_regwrt(mrw1), .mem_dest(md1),
    .mem_data(md1d), .wb_regwrt(wrw1), .wb_dest(wd1), .wb_data(wd1d));

  mem_stage #(.DEPTH(256), .RD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ex_valid(v), .ex_alu_result(alu), .ex_store_data(sd),
    .ex_dest(dest), .ex_mem_ctrl(mc), .ex_wb_ctrl(wc), .ex_branch_taken(bt), .ex_branch_target(tgt),
    .pc_src(pc3), .branch_target(bt3), .flush(fl3), .stall(st3), .mem_regwrt(mrw3), .mem_dest(md3),
    .mem_data(md3d), .wb_regwrt(wrw3), .wb_dest(wd3), .wb_data(wd3d));

  typedef struct {
    logic       v;
    logic [7:0] alu, sd;
    logic [3:0] dest;
    logic [1:0] mc, wc;
    logic [3:0] bt;
    logic [7:0] tgt;
    logic       pc;
    logic [7:0] btgt;
    logic       mrw;
    logic [3:0] md;
    logic [7:0] mdat;
    logic       wrw;
    logic [3:0] wd;
    logic [7:0] wdat;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] ialu, input logic [7:0] isd, input logic [3:0] idest,
                       input logic [1:0] imc, input logic [1:0] iwc, input logic [3:0] ibt, input logic [7:0] itgt);
    v = iv; alu = ialu; sd = isd; dest = idest; mc = imc; wc = iwc; bt = ibt; tgt = itgt;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, " pc_src"}, {7'd0, pc1}, 8'h00);
    chk({tag, " flush"}, {7'd0, fl1}, 8'h00);
    chk({tag, " stall"}, {7'd0, st1}, 8'h00);
    chk({tag, " branch_target"}, bt1, 8'h00);
    chk({tag, " mem_regwrt"}, {7'd0, mrw1}, 8'h00);
    chk({tag, " mem_dest"}, {4'd0, md1}, 8'h00);
    chk({tag, " mem_data"}, md1d, 8'h00);
    chk({tag, " wb_regwrt"}, {7'd0, wrw1}, 8'h00);
    chk({tag, " wb_dest"}, {4'd0, wd1}, 8'h00);
    chk({tag, " wb_data"}, wd1d, 8'h00);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h10, 8'hA5, 4'h0, 2'b01, 2'b00, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h10, 1'b0, 4'h0, 8'h00};
    vecs[1]  = '{1'b1, 8'h10, 8'h00, 4'h3, 2'b10, 2'b11, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 4'h3, 8'h10, 1'b0, 4'h0, 8'h10};
    vecs[2]  = '{1'b1, 8'h7F, 8'h00, 4'h9, 2'b00, 2'b10, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 4'h9, 8'h7F, 1'b1, 4'h3, 8'hA5};
    vecs[3]  = '{1'b1, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'h7F};
    vecs[4]  = '{1'b0, 8'h55, 8'h00, 4'h5, 2'b00, 2'b10, 4'h1, 8'h33, 1'b0, 8'h33, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[5]  = '{1'b1, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h8, 8'h2C, 1'b1, 8'h2C, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[6]  = '{1'b1, 8'h44, 8'h00, 4'h6, 2'b00, 2'b10, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[7]  = '{1'b1, 8'h20, 8'hFF, 4'h0, 2'b11, 2'b00, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h20, 1'b0, 4'h0, 8'h00};
    vecs[8]  = '{1'b1, 8'h20, 8'h00, 4'h7, 2'b10, 2'b11, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 4'h7, 8'h20, 1'b0, 4'h0, 8'h20};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1, 4'h7, 8'hFF};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};

    drive(1'b0, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h0, 8'h00);
    #12;
    chk_zero1("reset");
    chk("reset stall3", {7'd0, st3}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].alu, vecs[i].sd, vecs[i].dest, vecs[i].mc, vecs[i].wc, vecs[i].bt, vecs[i].tgt);
      tick();
      chk($sformatf("v%0d pc_src", i), {7'd0, pc1}, {7'd0, vecs[i].pc});
      chk($sformatf("v%0d flush", i), {7'd0, fl1}, {7'd0, vecs[i].pc});
      chk($sformatf("v%0d stall", i), {7'd0, st1}, 8'h00);
      chk($sformatf("v%0d branch_target", i), bt1, vecs[i].btgt);
      chk($sformatf("v%0d mem_regwrt", i), {7'd0, mrw1}, {7'd0, vecs[i].mrw});
      chk($sformatf("v%0d mem_dest", i), {4'd0, md1}, {4'd0, vecs[i].md});
      chk($sformatf("v%0d mem_data", i), md1d, vecs[i].mdat);
      chk($sformatf("v%0d wb_regwrt", i), {7'd0, wrw1}, {7'd0, vecs[i].wrw});
      chk($sformatf("v%0d wb_dest", i), {4'd0, wd1}, {4'd0, vecs[i].wd});
      chk($sformatf("v%0d wb_data", i), wd1d, vecs[i].wdat);
    end

    drive(1'b1, 8'h66, 8'h00, 4'h2, 2'b00, 2'b10, 4'h0, 8'h00);
    tick();
    tick();
    chk("pre-reset mem_regwrt", {7'd0, mrw1}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_zero1("async reset");
    rst_n = 1'b1;
    drive(1'b1, 8'h3C, 8'h00, 4'hA, 2'b00, 2'b10, 4'h0, 8'h00);
    tick();
    chk("post-reset mem_regwrt", {7'd0, mrw1}, 8'h01);
    chk("post-reset mem_dest", {4'd0, md1}, 8'h0A);
    chk("post-reset mem_data", md1d, 8'h3C);
    chk("post-reset wb_regwrt", {7'd0, wrw1}, 8'h00);

    drive(1'b1, 8'h40, 8'h5A, 4'h0, 2'b01, 2'b00, 4'h0, 8'h00);
    tick();
    drive(1'b1, 8'h40, 8'h00, 4'h4, 2'b10, 2'b11, 4'h0, 8'h00);
    tick();
    chk("lat3 c1 stall", {7'd0, st3}, 8'h01);
    chk("lat3 c1 mem_dest", {4'd0, md3}, 8'h04);
    chk("lat3 c1 wb_regwrt", {7'd0, wrw3}, 8'h00);
    drive(1'b1, 8'h12, 8'h00, 4'h5, 2'b00, 2'b10, 4'h0, 8'h00);
    tick();
    chk("lat3 c2 stall", {7'd0, st3}, 8'h01);
    chk("lat3 c2 mem_dest held", {4'd0, md3}, 8'h04);
    chk("lat3 c2 mem_regwrt held", {7'd0, mrw3}, 8'h01);
    chk("lat3 c2 wb_regwrt", {7'd0, wrw3}, 8'h00);
    tick();
    chk("lat3 c3 stall", {7'd0, st3}, 8'h00);
    chk("lat3 wb_regwrt", {7'd0, wrw3}, 8'h01);
    chk("lat3 wb_dest", {4'd0, wd3}, 8'h04);
    chk("lat3 wb_data", wd3d, 8'h5A);
    chk("lat3 c3 mem_regwrt", {7'd0, mrw3}, 8'h00);
    tick();
    chk("lat3 next mem_dest", {4'd0, md3}, 8'h05);
    chk("lat3 next mem_data", md3d, 8'h12);
    chk("lat3 next stall", {7'd0, st3}, 8'h00);
    chk("lat3 next wb_regwrt", {7'd0, wrw3}, 8'h00);

    drive(1'b1, 8'h40, 8'h00, 4'h4, 2'b10, 2'b11, 4'h0, 8'h00);
    tick();
    chk("lat3 reload stall", {7'd0, st3}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("lat3 reset stall", {7'd0, st3}, 8'h00);
    chk("lat3 reset mem_regwrt", {7'd0, mrw3}, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 4'h0, 2'b00, 2'b00, 4'h0, 8'h00);
    tick();
    tick();
    chk("lat3 abandoned wb_regwrt", {7'd0, wrw3}, 8'h00);
    chk("lat3 abandoned stall", {7'd0, st3}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
